// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: sequences MOV/LDI/SWAP/CLR transfers over the 4x8 register file ports.
// All outputs are registered and loaded alongside the state they belong to.
module reg_xfer_ctrl #(
  parameter logic [7:0] CLR_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] dst,
  input  logic [1:0] src,
  input  logic [7:0] imm,
  output logic       busy,
  output logic       done,
  output logic       reg_r,
  output logic [7:0] reg_r_select,
  input  logic [7:0] reg_r_line,
  output logic       reg_w,
  output logic [7:0] reg_w_select,
  output logic [7:0] reg_w_line
);
  typedef enum logic [3:0] {IDLE, RD_A, RD_B, WR_A, WR_B, CLR0, CLR1, CLR2, CLR3, DONE} state_t;
  localparam logic [1:0] LDI = 2'd1, SWAP = 2'd2, CLR = 2'd3;
  state_t state;
  logic [1:0] op_q, dst_q, src_q;
  logic [7:0] tmp_a, tmp_b;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      tmp_a <= '0;
      tmp_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      reg_r <= 1'b0;
      reg_w <= 1'b0;
      reg_r_select <= '0;
      reg_w_select <= '0;
      reg_w_line <= '0;
    end else begin
      reg_r <= 1'b0;
      reg_w <= 1'b0;
      reg_r_select <= '0;
      reg_w_select <= '0;
      reg_w_line <= '0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          dst_q <= dst;
          src_q <= src;
          busy <= 1'b1;
          if (op == LDI) begin
            state <= WR_A;
            reg_w <= 1'b1;
            reg_w_select <= {6'd0, dst};
            reg_w_line <= imm;
          end else if (op == CLR) begin
            state <= CLR0;
            reg_w <= 1'b1;
            reg_w_line <= CLR_VALUE;
          end else begin
            state <= RD_A;
            reg_r <= 1'b1;
            reg_r_select <= {6'd0, src};
          end
        end
        RD_A: begin
          tmp_a <= reg_r_line;
          if (op_q == SWAP) begin
            state <= RD_B;
            reg_r <= 1'b1;
            reg_r_select <= {6'd0, dst_q};
          end else begin
            state <= WR_A;
            reg_w <= 1'b1;
            reg_w_select <= {6'd0, dst_q};
            reg_w_line <= reg_r_line;
          end
        end
        RD_B: begin
          tmp_b <= reg_r_line;
          state <= WR_A;
          reg_w <= 1'b1;
          reg_w_select <= {6'd0, dst_q};
          reg_w_line <= tmp_a;
        end
        WR_A: if (op_q == SWAP) begin
          state <= WR_B;
          reg_w <= 1'b1;
          reg_w_select <= {6'd0, src_q};
          reg_w_line <= tmp_b;
        end else begin
          state <= DONE;
          done <= 1'b1;
        end
        // the select register already holds the current CLR code, so step it
        CLR0, CLR1, CLR2: begin
          state <= state_t'(state + 4'd1);
          reg_w <= 1'b1;
          reg_w_select <= reg_w_select + 8'd1;
          reg_w_line <= CLR_VALUE;
        end
        WR_B, CLR3: begin
          state <= DONE;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
